// File: rtl/miss_refill_axi_if.sv
// Bus bundle for miss_refill_axi: lane miss/fill handshakes plus the AXI4 AR/R channels.
// master = refill engine, slave = lane caches together with the AXI interconnect.
interface miss_refill_axi_if #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 64,
  parameter int ID_W       = 4
);
  logic                    miss_req1;
  logic                    miss_req2;
  logic [ADDR_W-1:0]       miss_addr1;
  logic [ADDR_W-1:0]       miss_addr2;
  logic                    Stall_miss1;
  logic                    Stall_miss2;
  logic                    fill_valid;
  logic                    fill_ack1;
  logic                    fill_ack2;
  logic [ADDR_W-1:0]       fill_addr;
  logic [LINE_BYTES*8-1:0] fill_data;
  logic                    fill_err;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [ADDR_W-1:0]       m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic [ID_W-1:0]         m_axi_arid;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;
  logic [DATA_W-1:0]       m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic [ID_W-1:0]         m_axi_rid;

  modport master (
    input  miss_req1, miss_req2, miss_addr1, miss_addr2,
    output Stall_miss1, Stall_miss2, fill_valid, fill_ack1, fill_ack2,
    output fill_addr, fill_data, fill_err,
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid,
    output m_axi_rready
  );

  modport slave (
    output miss_req1, miss_req2, miss_addr1, miss_addr2,
    input  Stall_miss1, Stall_miss2, fill_valid, fill_ack1, fill_ack2,
    input  fill_addr, fill_data, fill_err,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid,
    input  m_axi_rready
  );
endinterface

// File: rtl/miss_refill_axi.sv
// Dual-lane cache-miss refill engine: one AXI4 INCR burst per missing line, whole line
// returned in a single fill pulse. Define MISS_MERGE_EN to merge same-line misses of both lanes.
module miss_refill_axi #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 64,
  parameter int ID_W       = 4
) (
  input logic               clk,
  input logic               reset,
  miss_refill_axi_if.master bus
);
  localparam int BEATS     = LINE_BYTES * 8 / DATA_W;
  localparam int LINE_W    = LINE_BYTES * 8;
  localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SIZE_LOG2 = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AR   = 2'd1;
  localparam logic [1:0] R    = 2'd2;
  localparam logic [1:0] FILL = 2'd3;

  function automatic logic [ADDR_W-1:0] align_f(input logic [ADDR_W-1:0] a);
    return a & ~OFF_MASK;
  endfunction

  // rlast must appear exactly on the final beat; anything else poisons the line.
  function automatic logic beat_err_f(input logic [1:0] resp, input logic last, input logic is_final);
    return (resp != 2'b00) || (last != is_final);
  endfunction

  logic [1:0]        state_r;
  logic              lane2_r;
  logic              both_r;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  beat_r;
  logic              err_r;
  logic [LINE_W-1:0] line_r;
  logic [ADDR_W-1:0] fill_addr_r;
  logic [LINE_W-1:0] fill_data_r;

  logic [ADDR_W-1:0] align1_s;
  logic [ADDR_W-1:0] align2_s;
  logic [LINE_W-1:0] line_next_s;
  logic              beat_s;
  logic              final_s;
  logic              fill_s;
  logic              merge_s;
  logic              extra1_s;
  logic              extra2_s;
  logic              ack1_s;
  logic              ack2_s;
  logic              unused_rid_s;

  assign align1_s     = align_f(bus.miss_addr1);
  assign align2_s     = align_f(bus.miss_addr2);
  assign beat_s       = (state_r == R) && bus.m_axi_rvalid;
  assign final_s      = (beat_r == CNT_W'(BEATS - 1));
  assign fill_s       = (state_r == FILL);
  assign unused_rid_s = ^bus.m_axi_rid;

`ifdef MISS_MERGE_EN
  assign merge_s  = bus.miss_req1 && bus.miss_req2 && (align1_s == align2_s);
  assign extra1_s = bus.miss_req1 && (align1_s == fill_addr_r);
  assign extra2_s = bus.miss_req2 && (align2_s == fill_addr_r);
`else
  assign merge_s  = 1'b0;
  assign extra1_s = 1'b0;
  assign extra2_s = 1'b0;
`endif

  assign ack1_s = fill_s && (!lane2_r || both_r || extra1_s);
  assign ack2_s = fill_s && ( lane2_r || both_r || extra2_s);

  assign bus.Stall_miss1   = bus.miss_req1 && !ack1_s;
  assign bus.Stall_miss2   = bus.miss_req2 && !ack2_s;
  assign bus.fill_valid    = fill_s;
  assign bus.fill_ack1     = ack1_s;
  assign bus.fill_ack2     = ack2_s;
  assign bus.fill_err      = fill_s && err_r;
  assign bus.fill_addr     = fill_addr_r;
  assign bus.fill_data     = fill_data_r;
  assign bus.m_axi_arvalid = (state_r == AR);
  assign bus.m_axi_araddr  = addr_r;
  assign bus.m_axi_arlen   = 8'(BEATS - 1);
  assign bus.m_axi_arsize  = 3'(SIZE_LOG2);
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arid    = {ID_W{1'b0}};
  assign bus.m_axi_rready  = (state_r == R);

  // Line buffer with the incoming beat merged into its slot.
  always_comb begin
    line_next_s = line_r;
    line_next_s[int'(beat_r) * DATA_W +: DATA_W] = bus.m_axi_rdata;
  end

  // Refill FSM: lane arbitration, AR issue, beat counting and the fill cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      lane2_r <= 1'b0;
      both_r  <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      beat_r  <= {CNT_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.miss_req1 || bus.miss_req2) begin
            lane2_r <= !bus.miss_req1;
            both_r  <= merge_s;
            addr_r  <= bus.miss_req1 ? align1_s : align2_s;
            state_r <= AR;
          end
        end
        AR: begin
          if (bus.m_axi_arready) begin
            beat_r  <= {CNT_W{1'b0}};
            state_r <= R;
          end
        end
        R: begin
          // Completion is by beat count only; rlast merely feeds the error bit.
          if (beat_s) begin
            beat_r <= beat_r + CNT_W'(1);
            if (beat_err_f(bus.m_axi_rresp, bus.m_axi_rlast, final_s)) begin
              err_r <= 1'b1;
            end
            if (final_s) begin
              state_r <= FILL;
            end
          end
        end
        FILL: begin
          err_r   <= 1'b0;
          both_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Beat capture and the fill output registers, which hold between fills.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_r      <= {LINE_W{1'b0}};
      fill_addr_r <= {ADDR_W{1'b0}};
      fill_data_r <= {LINE_W{1'b0}};
    end else if (beat_s) begin
      line_r <= line_next_s;
      if (final_s) begin
        fill_addr_r <= addr_r;
        fill_data_r <= line_next_s;
      end
    end
  end
endmodule

// File: tb/tb_miss_refill_axi.sv
// Self-checking bench for miss_refill_axi: scenario table, reset sequences and random
// scenarios scored against a line-level model of the refill engine.
module tb_miss_refill_axi;
  localparam int BEATS  = 8;
  localparam int LINE_W = 512;
`ifdef MISS_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  typedef struct {
    logic r1; logic r2; logic [63:0] a1; logic [63:0] a2;
    int bad_beat; int last_beat; int ar_delay; int gap; bit plain;
    int exp_nfill; logic [63:0] exp_addr; logic exp_ack1; logic exp_ack2; logic exp_err; int exp_cyc;
  } scn_t;

  typedef struct { logic [63:0] addr; logic ack1; logic ack2; } fill_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  fill_t exp_q[$];
  scn_t  tbl[8];

  miss_refill_axi_if #(.ADDR_W(64), .DATA_W(64), .LINE_BYTES(64), .ID_W(4)) bus ();

  miss_refill_axi #(.ADDR_W(64), .DATA_W(64), .LINE_BYTES(64), .ID_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_line(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] line_of(input logic [63:0] a);
    return a & ~64'h3F;
  endfunction

  function automatic logic [63:0] data_f(input logic [63:0] a, input int k, input bit plain);
    if (plain) return 64'(k);
    return {a[31:0], 32'h5A5A_0000 | 32'(k)};
  endfunction

  function automatic scn_t mk(input logic r1, input logic r2, input logic [63:0] a1, input logic [63:0] a2,
                              input int bad_beat, input int last_beat, input int ar_delay, input int gap,
                              input bit plain, input int nfill, input logic [63:0] eaddr,
                              input logic ea1, input logic ea2, input logic eerr, input int ecyc);
    scn_t s;
    s.r1 = r1; s.r2 = r2; s.a1 = a1; s.a2 = a2;
    s.bad_beat = bad_beat; s.last_beat = last_beat; s.ar_delay = ar_delay; s.gap = gap; s.plain = plain;
    s.exp_nfill = nfill; s.exp_addr = eaddr; s.exp_ack1 = ea1; s.exp_ack2 = ea2; s.exp_err = eerr;
    s.exp_cyc = ecyc;
    return s;
  endfunction

  // Reference model: which fills the requests produce, in order, at line granularity.
  task automatic build_exp(input scn_t s);
    exp_q.delete();
    if (s.r1 && s.r2 && MERGE && (line_of(s.a1) == line_of(s.a2))) begin
      exp_q.push_back('{line_of(s.a1), 1'b1, 1'b1});
    end else begin
      if (s.r1) exp_q.push_back('{line_of(s.a1), 1'b1, 1'b0});
      if (s.r2) exp_q.push_back('{line_of(s.a2), 1'b0, 1'b1});
    end
  endtask

  task automatic quiet_inputs();
    bus.miss_req1 = 1'b0; bus.miss_req2 = 1'b0;
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
    bus.m_axi_rresp = 2'b00; bus.m_axi_rdata = 64'h0; bus.m_axi_rid = 4'h0;
  endtask

  task automatic idle_gap();
    quiet_inputs();
    @(negedge clk);
    chk("idle_arvalid", bus.m_axi_arvalid, 1'b0);
    chk("idle_rready", bus.m_axi_rready, 1'b0);
    chk("idle_fill_valid", bus.fill_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  // Entered at posedge+1 with the DUT idle; cycle 0 is the first cycle requests are driven.
  task automatic run_scn(input scn_t s);
    int cyc, nfill, ar_cnt, beat, first_cyc, last_fill_cyc;
    logic pend1, pend2, in_burst, prev_arv, ack1_e, ack2_e, exp_err;
    logic [63:0] baddr, first_addr;
    logic first_a1, first_a2, first_err;
    logic [LINE_W-1:0] line_e;
    fill_t e;
    build_exp(s);
    pend1 = s.r1; pend2 = s.r2; in_burst = 1'b0; prev_arv = 1'b0; baddr = 64'h0;
    cyc = 0; nfill = 0; ar_cnt = 0; beat = 0; first_cyc = -1; last_fill_cyc = -1;
    first_addr = 64'h0; first_a1 = 1'b0; first_a2 = 1'b0; first_err = 1'b0;
    exp_err = (s.bad_beat >= 0 && s.bad_beat < BEATS) || (s.last_beat != BEATS - 1);
    while ((pend1 || pend2 || in_burst) && cyc < 400) begin
      bus.miss_req1 = pend1; bus.miss_addr1 = s.a1;
      bus.miss_req2 = pend2; bus.miss_addr2 = s.a2;
      bus.m_axi_arready = bus.m_axi_arvalid && (ar_cnt >= s.ar_delay);
      if (in_burst && beat < BEATS && ($urandom_range(0, 99) >= s.gap)) begin
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = data_f(baddr, beat, s.plain);
        bus.m_axi_rresp  = (beat == s.bad_beat) ? 2'b10 : 2'b00;
        bus.m_axi_rlast  = (beat == s.last_beat);
      end else begin
        bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0; bus.m_axi_rresp = 2'b00;
      end
      @(negedge clk);
      ack1_e = bus.fill_valid && (exp_q.size() > 0) && exp_q[0].ack1;
      ack2_e = bus.fill_valid && (exp_q.size() > 0) && exp_q[0].ack2;
      chk("stall1", bus.Stall_miss1, pend1 && !ack1_e);
      chk("stall2", bus.Stall_miss2, pend2 && !ack2_e);
      if (bus.m_axi_arvalid) begin
        if (!prev_arv && s.gap == 0 && last_fill_cyc >= 0) chk("ar_after_fill", 64'(cyc), 64'(last_fill_cyc + 2));
        if (exp_q.size() == 0) chk("unexpected_ar", 64'd1, 64'd0);
        else chk("araddr", bus.m_axi_araddr, exp_q[0].addr);
        chk("arlen", bus.m_axi_arlen, 8'd7);
        chk("arsize", bus.m_axi_arsize, 3'd3);
        chk("arburst", bus.m_axi_arburst, 2'b01);
        chk("arid", bus.m_axi_arid, 4'h0);
        if (bus.m_axi_arready) begin
          in_burst = 1'b1; beat = 0; baddr = bus.m_axi_araddr; ar_cnt = 0;
        end else begin
          ar_cnt++;
        end
      end
      prev_arv = bus.m_axi_arvalid;
      if (bus.m_axi_rvalid && bus.m_axi_rready) begin
        beat++;
        if (beat == BEATS) in_burst = 1'b0;
      end
      if (bus.fill_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fill", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < BEATS; k++) line_e[k*64 +: 64] = data_f(e.addr, k, s.plain);
          chk("fill_addr", bus.fill_addr, e.addr);
          chk("fill_ack1", bus.fill_ack1, e.ack1);
          chk("fill_ack2", bus.fill_ack2, e.ack2);
          chk("fill_err", bus.fill_err, exp_err);
          chk_line("fill_data", bus.fill_data, line_e);
          if (nfill == 0) begin
            first_cyc = cyc; first_addr = bus.fill_addr;
            first_a1 = bus.fill_ack1; first_a2 = bus.fill_ack2; first_err = bus.fill_err;
          end
          nfill++;
          last_fill_cyc = cyc;
        end
        if (bus.fill_ack1) pend1 = 1'b0;
        if (bus.fill_ack2) pend2 = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_in_budget", 64'(pend1 || pend2 || in_burst), 64'd0);
    chk("fills_left", 64'(exp_q.size()), 64'd0);
    if (s.exp_nfill >= 0) begin
      chk("tbl_nfill", 64'(nfill), 64'(s.exp_nfill));
      chk("tbl_addr", first_addr, s.exp_addr);
      chk("tbl_ack1", first_a1, s.exp_ack1);
      chk("tbl_ack2", first_a2, s.exp_ack2);
      chk("tbl_err", first_err, s.exp_err);
      if (s.exp_cyc >= 0) chk("tbl_fill_cycle", 64'(first_cyc), 64'(s.exp_cyc));
    end
    idle_gap();
  endtask

  initial begin
    scn_t rs;
    total = 0; bad = 0;
    clk = 1'b0; reset = 1'b1;
    quiet_inputs();
    bus.miss_addr1 = 64'h1038; bus.miss_addr2 = 64'h0;
    bus.m_axi_rdata = 64'h0;
    bus.miss_req1 = 1'b1;

    tbl[0] = mk(1'b1, 1'b0, 64'h1038, 64'h0,    -1, 7, 0, 0,  1'b1, 1, 64'h1000, 1'b1, 1'b0, 1'b0, 10);
    tbl[1] = mk(1'b1, 1'b1, 64'h2000, 64'h3000, -1, 7, 0, 0,  1'b0, 2, 64'h2000, 1'b1, 1'b0, 1'b0, 10);
`ifdef MISS_MERGE_EN
    tbl[2] = mk(1'b1, 1'b1, 64'h4008, 64'h4030, -1, 7, 0, 0,  1'b0, 1, 64'h4000, 1'b1, 1'b1, 1'b0, 10);
`else
    tbl[2] = mk(1'b1, 1'b1, 64'h4008, 64'h4030, -1, 7, 0, 0,  1'b0, 2, 64'h4000, 1'b1, 1'b0, 1'b0, 10);
`endif
    tbl[3] = mk(1'b0, 1'b1, 64'h0,    64'h5010,  3, 5, 0, 0,  1'b0, 1, 64'h5000, 1'b0, 1'b1, 1'b1, 10);
    tbl[4] = mk(1'b1, 1'b0, 64'h6000, 64'h0,    -1, 7, 0, 0,  1'b0, 1, 64'h6000, 1'b1, 1'b0, 1'b0, 10);
    tbl[5] = mk(1'b1, 1'b0, 64'h7040, 64'h0,    -1, 7, 5, 40, 1'b0, 1, 64'h7040, 1'b1, 1'b0, 1'b0, -1);
    tbl[6] = mk(1'b0, 1'b1, 64'h0,    64'h8ff8, -1, 7, 2, 0,  1'b0, 1, 64'h8fc0, 1'b0, 1'b1, 1'b0, 12);
    tbl[7] = mk(1'b1, 1'b1, 64'h9000, 64'h0100, -1, 7, 0, 0,  1'b0, 2, 64'h9000, 1'b1, 1'b0, 1'b0, 10);

    // Reset state, with lane 1 requesting so the stall path is visible.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", bus.m_axi_arvalid, 1'b0);
    chk("rst_rready", bus.m_axi_rready, 1'b0);
    chk("rst_fill_valid", bus.fill_valid, 1'b0);
    chk("rst_ack1", bus.fill_ack1, 1'b0);
    chk("rst_ack2", bus.fill_ack2, 1'b0);
    chk("rst_err", bus.fill_err, 1'b0);
    chk("rst_fill_addr", bus.fill_addr, 64'h0);
    chk_line("rst_fill_data", bus.fill_data, {LINE_W{1'b0}});
    chk("rst_stall1", bus.Stall_miss1, 1'b1);
    chk("rst_stall2", bus.Stall_miss2, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    quiet_inputs();
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_scn(tbl[i]);

    // Reset lands on beat 4 of a burst; the engine must drop everything the next cycle.
    for (int c = 0; c < 8; c++) begin
      bus.miss_req1 = (c < 7); bus.miss_addr1 = 64'h1038; bus.miss_req2 = 1'b0;
      reset = (c == 6);
      bus.m_axi_arready = (c == 1);
      bus.m_axi_rvalid = (c >= 2 && c < 7);
      bus.m_axi_rdata = 64'(c - 2); bus.m_axi_rresp = 2'b00; bus.m_axi_rlast = 1'b0;
      @(negedge clk);
      if (c == 1) chk("rstseq_arvalid", bus.m_axi_arvalid, 1'b1);
      if (c >= 2 && c < 7) chk("rstseq_rready", bus.m_axi_rready, 1'b1);
      if (c == 7) begin
        chk("rstseq_post_arvalid", bus.m_axi_arvalid, 1'b0);
        chk("rstseq_post_rready", bus.m_axi_rready, 1'b0);
        chk("rstseq_post_fill", bus.fill_valid, 1'b0);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    idle_gap();
    run_scn(mk(1'b1, 1'b0, 64'h1038, 64'h0, -1, 7, 0, 0, 1'b1, 1, 64'h1000, 1'b1, 1'b0, 1'b0, 10));

    // Random scenarios scored only by the model.
    for (int i = 0; i < 30; i++) begin
      rs.r1 = 1'($urandom_range(0, 1));
      rs.r2 = rs.r1 ? 1'($urandom_range(0, 1)) : 1'b1;
      rs.a1 = 64'h0001_0000 + 64'($urandom_range(0, 255));
      rs.a2 = 64'h0001_0000 + 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rs.bad_beat = int'($urandom_range(0, 7));
      else rs.bad_beat = -1;
      if ($urandom_range(0, 4) == 0) rs.last_beat = int'($urandom_range(0, 7));
      else rs.last_beat = 7;
      rs.ar_delay = int'($urandom_range(0, 3));
      rs.gap = int'($urandom_range(0, 60));
      rs.plain = 1'b0;
      rs.exp_nfill = -1; rs.exp_addr = 64'h0; rs.exp_ack1 = 1'b0; rs.exp_ack2 = 1'b0;
      rs.exp_err = 1'b0; rs.exp_cyc = -1;
      run_scn(rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
